id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- RV32I decode stage, directly downstream of the fetch stage.
- Consumes the fetched instruction word and the fetch stage's PC+4 value.
- Reads a 32x32 register file owned by this block and decodes controls and immediates.
- Presents one registered ID/EX bundle per cycle, with load-use hazard detection and writeback port.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, architectural register count (x0 hardwired zero).
- RESET_PC, 32'h0000_0000, value driven on pc_out under reset/bubble.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled only on the rising edge of clk.
- pc_plus4_in  in  XLEN  PC+4 of the incoming instruction, from fetch.
- instr_in  in  32  fetched instruction; 32'h0 is treated as a bubble.
- stall_in  in  1  downstream hold; freeze all outputs.
- flush_in  in  1  kill the incoming instruction (branch redirect).
- wb_en  in  1  register write enable from writeback.
- wb_rd  in  5  writeback destination.
- wb_data  in  XLEN  writeback value.
- stall_req  out  1  combinational; asks fetch to hold pc/instr for one cycle.
- valid_out  out  1  ID/EX bundle valid.
- pc_out  out  XLEN  PC of the decoded instruction (pc_plus4_in - 4).
- rs1_data, rs2_data  out  XLEN  register operands.
- imm_out  out  XLEN  sign-extended immediate.
- rs1_out, rs2_out, rd_out  out  5  register indices.
- funct3_out  out  3; funct7b5_out  out  1.
- reg_write, alu_src, mem_read, mem_write, branch, jump, jalr, lui, auipc  out  1 each  control bits.
- illegal_out  out  1  unsupported opcode seen.

Behaviour:
- Reset (reset==0 at edge): valid_out=0, pc_out=RESET_PC, all data/index/control outputs 0, illegal_out=0, all registers x1..x31 cleared to 0.
- Latency: 1 cycle; instruction presented in cycle N appears on outputs after edge N+1.
- Decode: opcodes 0110011(R), 0010011(I), 0000011(LOAD), 0100011(S), 1100011(B), 1101111(JAL), 1100111(JALR), 0110111(LUI), 0010111(AUIPC).
- Immediates use standard I/S/B/U/J formats, sign-extended from bit 31. B and J have bit0=0; U is instr[31:12]<<12. R-type imm=0.
- Controls:
  - reg_write=1 for R, I, LOAD, JAL, JALR, LUI, AUIPC; forced 0 when rd==0.
  - alu_src=1 for all non-R/non-B types.
- Operand reads: rs1/rs2 index 0 reads 0. Writes with wb_rd==0 are ignored.
- Bubble: illegal opcode, instr_in==0, flush_in, or stall_req. A bubble registers valid_out=0 and all controls=0. illegal_out=1 only for an illegal non-zero instruction, and only when not flushed.
- Hazard:
  - Condition: stall_req=1 when the current outputs have valid_out&mem_read&rd_out!=0, and rd_out equals a used rs1/rs2 of instr_in (rs2 used only by R/S/B).
  - Effect: inserts exactly one bubble. Fetch re-presents the same instruction next cycle, which then decodes normally.
- Priority per edge: reset > stall_in (hold all outputs, regfile write still occurs) > flush_in > stall_req bubble > normal decode.
- stall_req is not asserted while stall_in=1.
- Regfile write occurs on every edge with wb_en=1 regardless of stall/flush, but not during reset.

Optional Feature:
- ID_WB_BYPASS_EN
  - Defined: a same-cycle write (wb_en, wb_rd!=0) matching rs1/rs2 supplies wb_data to the registered operand.
  - Undefined: the old register value is registered; the pipeline must separately tolerate the 1-cycle WB->ID gap.

Test Plan:
- Reset held low 2 cycles with instr_in=32'h00100093 -> valid_out=0, all outputs 0, pc_out=0. After release: rd_out=1, imm_out=1, reg_write=1, alu_src=1, valid_out=1, one cycle later.
- instr 0x0000A283 (lw x5,0(x1)), then 0x001283B3 (add x7,x5,x1):
  - stall_req=1 during the add cycle, followed by a bubble.
  - The add is re-presented and decodes with valid_out=1, rs1_out=5, rs2_out=1, stall_req=0.
- wb_en=1, wb_rd=2, wb_data=32'hDEADBEEF, same cycle instr reading x2 -> rs1_data=DEADBEEF with macro, 0 without. The next read of x2 returns DEADBEEF in both builds.
- wb_en=1, wb_rd=0, wb_data=32'hFFFF_FFFF, then read x0 -> rs1_data=0.
- flush_in=1 with a valid add -> valid_out=0, reg_write=0, illegal_out=0 next cycle. stall_in=1 for 3 cycles -> outputs unchanged across all 3.
- instr 0xFE000EE3 (beq x0,x0,-4), pc_plus4_in=0x14 -> branch=1, imm_out=0xFFFF_FFFC, pc_out=0x10. Opcode 0x7F -> illegal_out=1, valid_out=0.

Source files
------------

// File: rtl/id_stage.sv
// RV32I decode stage: register file, instruction decode, load-use hazard detection
// and a registered ID/EX bundle with one cycle of latency.
// Optional feature: define ID_WB_BYPASS_EN to forward a same-cycle writeback value
// into the registered rs1/rs2 operands.
module id_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_plus4_in,
    input  logic [31:0]     instr_in,
    input  logic            stall_in,
    input  logic            flush_in,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall_req,
    output logic            valid_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] imm_out,
    output logic [4:0]      rs1_out,
    output logic [4:0]      rs2_out,
    output logic [4:0]      rd_out,
    output logic [2:0]      funct3_out,
    output logic            funct7b5_out,
    output logic            reg_write,
    output logic            alu_src,
    output logic            mem_read,
    output logic            mem_write,
    output logic            branch,
    output logic            jump,
    output logic            jalr,
    output logic            lui,
    output logic            auipc,
    output logic            illegal_out
);

    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic            reg_write;
        logic            alu_src;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic            lui;
        logic            auipc;
        logic            illegal;
    } idex_t;

    logic [XLEN-1:0] regs_q [NREGS];
    idex_t           idex_q, idex_d, dec, bubble;

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    logic            is_r, is_i, is_load, is_s, is_b, is_jal, is_jalr, is_lui, is_auipc;
    logic            legal, uses_rs1, uses_rs2;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] rf_rs1, rf_rs2, op_rs1, op_rs2;

    assign opcode = instr_in[6:0];
    assign rd     = instr_in[11:7];
    assign rs1    = instr_in[19:15];
    assign rs2    = instr_in[24:20];

    assign is_r     = (opcode == OpR);
    assign is_i     = (opcode == OpImm);
    assign is_load  = (opcode == OpLoad);
    assign is_s     = (opcode == OpStore);
    assign is_b     = (opcode == OpBr);
    assign is_jal   = (opcode == OpJal);
    assign is_jalr  = (opcode == OpJalr);
    assign is_lui   = (opcode == OpLui);
    assign is_auipc = (opcode == OpAuipc);
    assign legal    = is_r | is_i | is_load | is_s | is_b | is_jal | is_jalr | is_lui | is_auipc;

    // U/J types carry no source registers; only R/S/B read rs2
    assign uses_rs1 = is_r | is_i | is_load | is_s | is_b | is_jalr;
    assign uses_rs2 = is_r | is_s | is_b;

    assign imm_i = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
    assign imm_s = {{(XLEN-12){instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    assign imm_b = {{(XLEN-13){instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25],
                    instr_in[11:8], 1'b0};
    assign imm_u = XLEN'($signed({instr_in[31:12], 12'b0}));
    assign imm_j = {{(XLEN-21){instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20],
                    instr_in[30:21], 1'b0};

    assign rf_rs1 = (rs1 == 5'd0) ? '0 : regs_q[rs1];
    assign rf_rs2 = (rs2 == 5'd0) ? '0 : regs_q[rs2];

`ifdef ID_WB_BYPASS_EN
    assign op_rs1 = (wb_en && wb_rd != 5'd0 && wb_rd == rs1) ? wb_data : rf_rs1;
    assign op_rs2 = (wb_en && wb_rd != 5'd0 && wb_rd == rs2) ? wb_data : rf_rs2;
`else
    assign op_rs1 = rf_rs1;
    assign op_rs2 = rf_rs2;
`endif

    // Load-use hazard against the bundle currently held in ID/EX
    assign stall_req = !stall_in && idex_q.valid && idex_q.mem_read && (idex_q.rd != 5'd0) &&
                       ((uses_rs1 && rs1 == idex_q.rd) || (uses_rs2 && rs2 == idex_q.rd));

    // Full decode of the incoming instruction, assuming it is legal and not killed
    always_comb begin
        dec           = '0;
        dec.valid     = 1'b1;
        dec.pc        = pc_plus4_in - XLEN'(4);
        dec.rs1_data  = op_rs1;
        dec.rs2_data  = op_rs2;
        dec.rs1       = rs1;
        dec.rs2       = rs2;
        dec.rd        = rd;
        dec.funct3    = instr_in[14:12];
        dec.funct7b5  = instr_in[30];
        dec.reg_write = (is_r | is_i | is_load | is_jal | is_jalr | is_lui | is_auipc) &&
                        (rd != 5'd0);
        dec.alu_src   = legal & ~is_r & ~is_b;
        dec.mem_read  = is_load;
        dec.mem_write = is_s;
        dec.branch    = is_b;
        // jump covers both unconditional jumps; jalr tells them apart
        dec.jump      = is_jal | is_jalr;
        dec.jalr      = is_jalr;
        dec.lui       = is_lui;
        dec.auipc     = is_auipc;
        if (is_i || is_load || is_jalr) begin
            dec.imm = imm_i;
        end else if (is_s) begin
            dec.imm = imm_s;
        end else if (is_b) begin
            dec.imm = imm_b;
        end else if (is_lui || is_auipc) begin
            dec.imm = imm_u;
        end else if (is_jal) begin
            dec.imm = imm_j;
        end
    end

    // Next ID/EX bundle: flush, then hazard bubble, then illegal/zero bubble, else decode
    always_comb begin
        bubble    = '0;
        bubble.pc = RESET_PC;
        idex_d    = dec;
        if (flush_in || stall_req) begin
            idex_d = bubble;
        end else if (!legal) begin
            idex_d         = bubble;
            idex_d.illegal = (instr_in != 32'h0);
        end
    end

    // ID/EX register; stall_in freezes the whole bundle
    always_ff @(posedge clk) begin
        if (!reset) begin
            idex_q <= bubble;
        end else if (!stall_in) begin
            idex_q <= idex_d;
        end
    end

    // Register file; writeback is independent of stall and flush
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en && wb_rd != 5'd0) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    assign valid_out    = idex_q.valid;
    assign pc_out       = idex_q.pc;
    assign rs1_data     = idex_q.rs1_data;
    assign rs2_data     = idex_q.rs2_data;
    assign imm_out      = idex_q.imm;
    assign rs1_out      = idex_q.rs1;
    assign rs2_out      = idex_q.rs2;
    assign rd_out       = idex_q.rd;
    assign funct3_out   = idex_q.funct3;
    assign funct7b5_out = idex_q.funct7b5;
    assign reg_write    = idex_q.reg_write;
    assign alu_src      = idex_q.alu_src;
    assign mem_read     = idex_q.mem_read;
    assign mem_write    = idex_q.mem_write;
    assign branch       = idex_q.branch;
    assign jump         = idex_q.jump;
    assign jalr         = idex_q.jalr;
    assign lui          = idex_q.lui;
    assign auipc        = idex_q.auipc;
    assign illegal_out  = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic checked
// against a behavioural decode model. Honours ID_WB_BYPASS_EN when defined.
module tb_id_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        f7b5;
        logic        reg_write;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        lui;
        logic        auipc;
        logic        illegal;
    } bundle_t;

    logic        clk = 1'b0;
    logic        reset, stall_in, flush_in, wb_en;
    logic [31:0] pc_plus4_in, instr_in, wb_data;
    logic [4:0]  wb_rd;
    logic        stall_req, valid_out, funct7b5_out;
    logic [31:0] pc_out, rs1_data, rs2_data, imm_out;
    logic [4:0]  rs1_out, rs2_out, rd_out;
    logic [2:0]  funct3_out;
    logic        reg_write, alu_src, mem_read, mem_write, branch, jump, jalr, lui, auipc;
    logic        illegal_out;

    bundle_t     obs, m_out;
    logic [31:0] m_rf [32];
    logic        m_stall, s_stall;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    id_stage #(.XLEN(32), .NREGS(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .pc_plus4_in(pc_plus4_in), .instr_in(instr_in),
        .stall_in(stall_in), .flush_in(flush_in), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .stall_req(stall_req), .valid_out(valid_out), .pc_out(pc_out),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_out(imm_out), .rs1_out(rs1_out),
        .rs2_out(rs2_out), .rd_out(rd_out), .funct3_out(funct3_out),
        .funct7b5_out(funct7b5_out), .reg_write(reg_write), .alu_src(alu_src),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .jump(jump),
        .jalr(jalr), .lui(lui), .auipc(auipc), .illegal_out(illegal_out)
    );

    assign obs = {valid_out, pc_out, rs1_data, rs2_data, imm_out, rs1_out, rs2_out, rd_out,
                  funct3_out, funct7b5_out, reg_write, alu_src, mem_read, mem_write, branch,
                  jump, jalr, lui, auipc, illegal_out};

    // ---------------- reference model ----------------
    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        if (v[bits-1]) return v - (32'd1 << bits);
        return v;
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    endfunction

    function automatic logic reads_rs1(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return op inside {7'h33, 7'h23, 7'h63};
    endfunction

    function automatic logic [31:0] rd_reg(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
        if (wb_en && wb_rd == r) return wb_data;
`endif
        return m_rf[r];
    endfunction

    function automatic bundle_t model_decode(input logic [31:0] ins, input logic [31:0] pc4);
        bundle_t b;
        logic [31:0] ii, is, ib, ij;
        ii = sext(32'(ins[31:20]), 12);
        is = sext(32'(ins[31:25]) * 32'd32 + 32'(ins[11:7]), 12);
        ib = sext(32'(ins[31]) * 32'd4096 + 32'(ins[7]) * 32'd2048 +
                  32'(ins[30:25]) * 32'd32 + 32'(ins[11:8]) * 32'd2, 13);
        ij = sext(32'(ins[31]) * 32'h0010_0000 + 32'(ins[19:12]) * 32'd4096 +
                  32'(ins[20]) * 32'd2048 + 32'(ins[30:21]) * 32'd2, 21);
        b = '0;
        b.valid = 1'b1;
        b.pc = pc4 - 32'd4;
        b.rs1 = ins[19:15];
        b.rs2 = ins[24:20];
        b.rd = ins[11:7];
        b.funct3 = ins[14:12];
        b.f7b5 = ins[30];
        b.rs1_data = rd_reg(ins[19:15]);
        b.rs2_data = rd_reg(ins[24:20]);
        case (ins[6:0])
            7'h33: b.reg_write = 1'b1;
            7'h13: begin b.reg_write = 1'b1; b.alu_src = 1'b1; b.imm = ii; end
            7'h03: begin b.reg_write = 1'b1; b.alu_src = 1'b1; b.mem_read = 1'b1; b.imm = ii; end
            7'h23: begin b.alu_src = 1'b1; b.mem_write = 1'b1; b.imm = is; end
            7'h63: begin b.branch = 1'b1; b.imm = ib; end
            7'h6F: begin b.reg_write = 1'b1; b.alu_src = 1'b1; b.jump = 1'b1; b.imm = ij; end
            7'h67: begin
                b.reg_write = 1'b1; b.alu_src = 1'b1; b.jump = 1'b1; b.jalr = 1'b1; b.imm = ii;
            end
            7'h37: begin b.reg_write = 1'b1; b.alu_src = 1'b1; b.lui = 1'b1;
                         b.imm = ins & 32'hFFFF_F000; end
            7'h17: begin b.reg_write = 1'b1; b.alu_src = 1'b1; b.auipc = 1'b1;
                         b.imm = ins & 32'hFFFF_F000; end
            default: ;
        endcase
        if (b.rd == 5'd0) b.reg_write = 1'b0;
        return b;
    endfunction

    function automatic logic model_stall(input logic [31:0] ins);
        if (stall_in || !(m_out.valid && m_out.mem_read && m_out.rd != 5'd0)) return 1'b0;
        return (reads_rs1(ins[6:0]) && ins[19:15] == m_out.rd) ||
               (reads_rs2(ins[6:0]) && ins[24:20] == m_out.rd);
    endfunction

    // Drive one cycle of inputs, sample stall_req, advance the model and the DUT by one edge
    task automatic step(input logic rst, input logic st, input logic fl, input logic [31:0] ins,
                        input logic [31:0] pc4, input logic we, input logic [4:0] wr,
                        input logic [31:0] wd);
        bundle_t nxt, bub;
        reset = rst; stall_in = st; flush_in = fl; instr_in = ins; pc_plus4_in = pc4;
        wb_en = we; wb_rd = wr; wb_data = wd;
        #1;
        s_stall = stall_req;
        m_stall = model_stall(ins);
        bub = '0;
        bub.pc = RESET_PC;
        if (!rst) nxt = bub;
        else if (st) nxt = m_out;
        else if (fl || m_stall) nxt = bub;
        else if (!is_legal(ins[6:0])) begin nxt = bub; nxt.illegal = (ins != 32'h0); end
        else nxt = model_decode(ins, pc4);
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        end else if (we && wr != 5'd0) begin
            m_rf[wr] = wd;
        end
        m_out = nxt;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        step(0, 0, 0, 32'h0010_0093, 32'h4, 0, 0, 0);
        step(0, 0, 0, 32'h0010_0093, 32'h4, 0, 0, 0);
        n_checks++;
        if (obs !== '0) begin
            n_fail++; $display("FAIL reset_zero: got %h want 0", obs);
        end
        n_checks++;
        if (pc_out !== RESET_PC || valid_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_pc_valid: got pc=%h v=%b want pc=%h v=0",
                                pc_out, valid_out, RESET_PC);
        end
        step(1, 0, 0, 32'h0010_0093, 32'h4, 0, 0, 0);
        n_checks++;
        if ({valid_out, reg_write, alu_src, rd_out, imm_out} !== {3'b111, 5'd1, 32'd1}) begin
            n_fail++; $display("FAIL reset_release_addi: got v=%b rw=%b as=%b rd=%0d imm=%h",
                                valid_out, reg_write, alu_src, rd_out, imm_out);
        end
        n_checks++;
        if (obs !== m_out) begin
            n_fail++; $display("FAIL reset_release_bundle: got %h want %h", obs, m_out);
        end
    endtask

    task automatic test_load_use();
        step(1, 0, 0, 32'h0000_A283, 32'h8, 0, 0, 0);
        n_checks++;
        if ({valid_out, mem_read, rd_out} !== {2'b11, 5'd5}) begin
            n_fail++; $display("FAIL lu_load: got v=%b mr=%b rd=%0d want 1 1 5",
                                valid_out, mem_read, rd_out);
        end
        step(1, 0, 0, 32'h0012_83B3, 32'hC, 0, 0, 0);
        n_checks++;
        if (s_stall !== 1'b1) begin
            n_fail++; $display("FAIL lu_stall_req: got %b want 1", s_stall);
        end
        n_checks++;
        if (valid_out !== 1'b0 || reg_write !== 1'b0) begin
            n_fail++; $display("FAIL lu_bubble: got v=%b rw=%b want 0 0", valid_out, reg_write);
        end
        step(1, 0, 0, 32'h0012_83B3, 32'hC, 0, 0, 0);
        n_checks++;
        if (s_stall !== 1'b0) begin
            n_fail++; $display("FAIL lu_replay_stall: got %b want 0", s_stall);
        end
        n_checks++;
        if ({valid_out, rs1_out, rs2_out, rd_out} !== {1'b1, 5'd5, 5'd1, 5'd7}) begin
            n_fail++; $display("FAIL lu_replay: got v=%b rs1=%0d rs2=%0d rd=%0d want 1 5 1 7",
                                valid_out, rs1_out, rs2_out, rd_out);
        end
        n_checks++;
        if (obs !== m_out) begin
            n_fail++; $display("FAIL lu_bundle: got %h want %h", obs, m_out);
        end
    endtask

    task automatic test_wb_bypass();
`ifdef ID_WB_BYPASS_EN
        logic [31:0] want = 32'hDEAD_BEEF;
`else
        logic [31:0] want = 32'h0;
`endif
        step(1, 0, 0, 32'h0001_0193, 32'h10, 1, 5'd2, 32'hDEAD_BEEF);
        n_checks++;
        if (rs1_data !== want) begin
            n_fail++; $display("FAIL wb_same_cycle: got %h want %h", rs1_data, want);
        end
        step(1, 0, 0, 32'h0001_0193, 32'h14, 0, 0, 0);
        n_checks++;
        if (rs1_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL wb_next_read: got %h want deadbeef", rs1_data);
        end
    endtask

    task automatic test_x0_write();
        step(1, 0, 0, 32'h0000_0193, 32'h18, 1, 5'd0, 32'hFFFF_FFFF);
        n_checks++;
        if (rs1_data !== 32'h0) begin
            n_fail++; $display("FAIL x0_same_cycle: got %h want 0", rs1_data);
        end
        step(1, 0, 0, 32'h0000_0193, 32'h1C, 0, 0, 0);
        n_checks++;
        if (rs1_data !== 32'h0) begin
            n_fail++; $display("FAIL x0_read: got %h want 0", rs1_data);
        end
    endtask

    task automatic test_flush_stall();
        bundle_t saved;
        logic [31:0] d9;
        step(1, 0, 1, 32'h0012_83B3, 32'h20, 0, 0, 0);
        n_checks++;
        if ({valid_out, reg_write, illegal_out} !== 3'b000) begin
            n_fail++; $display("FAIL flush_add: got v=%b rw=%b il=%b want 000",
                                valid_out, reg_write, illegal_out);
        end
        step(1, 0, 1, 32'h0000_007F, 32'h24, 0, 0, 0);
        n_checks++;
        if (illegal_out !== 1'b0) begin
            n_fail++; $display("FAIL flush_illegal: got %b want 0", illegal_out);
        end
        step(1, 0, 0, 32'h0000_A283, 32'h28, 0, 0, 0);
        saved = obs;
        for (int i = 0; i < 3; i++) begin
            d9 = $urandom();
            step(1, 1, 0, 32'h0012_83B3, 32'h2C, 1, 5'd9, d9);
            n_checks++;
            if (obs !== saved) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got %h want %h", i, obs, saved);
            end
            n_checks++;
            if (s_stall !== 1'b0) begin
                n_fail++; $display("FAIL stall_no_req[%0d]: got %b want 0", i, s_stall);
            end
        end
        step(1, 0, 0, 32'h0012_83B3, 32'h2C, 0, 0, 0);
        n_checks++;
        if (s_stall !== 1'b1 || valid_out !== 1'b0) begin
            n_fail++; $display("FAIL stall_release: got req=%b v=%b want 1 0", s_stall, valid_out);
        end
        step(1, 0, 0, 32'h0004_8193, 32'h30, 0, 0, 0);
        n_checks++;
        if (rs1_data !== d9) begin
            n_fail++; $display("FAIL stall_wb_write: got %h want %h", rs1_data, d9);
        end
    endtask

    task automatic test_branch_illegal();
        step(1, 0, 0, 32'hFE00_0EE3, 32'h14, 0, 0, 0);
        n_checks++;
        if ({valid_out, branch, imm_out, pc_out} !== {2'b11, 32'hFFFF_FFFC, 32'h10}) begin
            n_fail++; $display("FAIL beq: got v=%b br=%b imm=%h pc=%h want 1 1 fffffffc 10",
                                valid_out, branch, imm_out, pc_out);
        end
        step(1, 0, 0, 32'h0000_007F, 32'h18, 0, 0, 0);
        n_checks++;
        if ({illegal_out, valid_out} !== 2'b10) begin
            n_fail++; $display("FAIL illegal: got il=%b v=%b want 1 0", illegal_out, valid_out);
        end
        step(1, 0, 0, 32'h0000_0000, 32'h1C, 0, 0, 0);
        n_checks++;
        if ({illegal_out, valid_out, pc_out} !== {2'b00, RESET_PC}) begin
            n_fail++; $display("FAIL zero_bubble: got il=%b v=%b pc=%h want 0 0 %h",
                                illegal_out, valid_out, pc_out, RESET_PC);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37,
                                   7'h17, 7'h7F, 7'h00};
        logic [31:0] rb, pr, ins;
        int          k;
        for (int n = 0; n < 400; n++) begin
            rb = $urandom();
            pr = $urandom();
            k  = $urandom_range(0, 10);
            ins = {rb[31:25], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), rb[14:12],
                   5'($urandom_range(0, 7)), ops[k]};
            if (k == 10) ins = 32'h0;
            step($urandom_range(0, 99) >= 2, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0, ins, {pr[31:2], 2'b00}, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 7)), $urandom());
            n_checks++;
            if (s_stall !== m_stall) begin
                n_fail++; $display("FAIL rand_stall_req[%0d]: got %b want %b", n, s_stall, m_stall);
            end
            n_checks++;
            if (obs !== m_out) begin
                n_fail++; $display("FAIL rand_bundle[%0d]: got %h want %h", n, obs, m_out);
            end
        end
    endtask

    initial begin
        m_out = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        test_reset();
        test_load_use();
        test_wb_bypass();
        test_x0_write();
        test_flush_stall();
        test_branch_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
